run_ctrl_eot: RTL and testbench

Synthesisable run controller and end-of-test monitor for the manta_style core, used in test harnesses and FPGA bring-up.
- Sequences core start-up: holds PC at zero and injects NOPs for a programmable number of cycles, then pulses a register-file clear.
- Releases the core and counts run cycles.
- Watches the data-memory write port for a parametrised end-of-test signature, then drains the pipeline.
- Reports done, timeout and a frozen cycle count.

---
 rtl/run_ctrl_eot.sv | 136 +++++++++++++
 tb/tb_run_ctrl_eot.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl_eot.sv
// Run controller and end-of-test monitor: sequences core start-up (PC hold, NOP
// injection, register-file clear), counts run cycles and watches for an EOT write.
module run_ctrl_eot #(
    parameter int          AW             = 16,
    parameter int          DW             = 16,
    parameter int          CW             = 32,
    parameter int unsigned EOT_ADDR       = 32'h0000_d074,
    parameter int unsigned EOT_DATA       = 32'h0000_d074,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned PC_HOLD_CYCLES = 9,
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mem_wr_en,
    input  logic [AW-1:0] mem_wr_dest,
    input  logic [DW-1:0] mem_wr_data,
    output logic          hold_pc,
    output logic          hold_instr,
    output logic          rf_clear,
    output logic          running,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // One phase counter serves both HOLD and DRAIN, so size it for the longer one.
    localparam int unsigned PMAX = (HOLD_CYCLES > DRAIN_CYCLES) ? HOLD_CYCLES : DRAIN_CYCLES;
    localparam int          PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PC_HOLD    = PW'(PC_HOLD_CYCLES);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES - 1);
    localparam logic [AW-1:0] EOT_A      = AW'(EOT_ADDR);
    localparam logic [DW-1:0] EOT_D      = DW'(EOT_DATA);
    localparam logic [CW-1:0] TO_LIMIT   = CW'(TIMEOUT_CYCLES);
    localparam bit            TO_EN      = (TIMEOUT_CYCLES != 0);

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [CW-1:0]   count_q, count_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   count_inc;
    logic            eot_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
    assign eot_match = mem_wr_en && (mem_wr_dest == EOT_A) && (mem_wr_data == EOT_D);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                phase_d   = '0;
                count_d   = '0;
                timeout_d = 1'b0;
                if (start) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    phase_d = '0;
                    state_d = RUN;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                // The match cycle is still counted; a match beats a simultaneous timeout.
                count_d = count_inc;
                if (eot_match) begin
                    phase_d = '0;
                    state_d = DRAIN;
                end else if (TO_EN && (count_inc == TO_LIMIT)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DRAIN: begin
                if (phase_q == DRAIN_LAST) begin
                    phase_d = '0;
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    phase_d   = '0;
                    count_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hold_instr  = (state_q == HOLD);
    assign hold_pc     = (state_q == HOLD) && (phase_q < PC_HOLD);
    assign rf_clear    = (state_q == HOLD) && (phase_q == HOLD_LAST);
    assign running     = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_ctrl_eot.sv
// Directed bench for run_ctrl_eot: default, timeout-enabled and 8-bit-counter instances
// share clock, reset and the memory write bus; each has its own start.
module tb_run_ctrl_eot;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_to = 1'b0;
    logic        start_c8 = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [15:0] mem_wr_dest = 16'h0;
    logic [15:0] mem_wr_data = 16'h0;

    logic        hold_pc, hold_instr, rf_clear, running, done, timeout;
    logic [31:0] cycle_count;
    logic        hold_pc_to, hold_instr_to, rf_clear_to, running_to, done_to, timeout_to;
    logic [31:0] cycle_count_to;
    logic        hold_pc_c8, hold_instr_c8, rf_clear_c8, running_c8, done_c8, timeout_c8;
    logic [7:0]  cycle_count_c8;

    int checks = 0;
    int errors = 0;

    // Flag order: {hold_pc, hold_instr, rf_clear, running, done, timeout}
    wire [5:0] flags    = {hold_pc, hold_instr, rf_clear, running, done, timeout};
    wire [5:0] flags_to = {hold_pc_to, hold_instr_to, rf_clear_to, running_to, done_to, timeout_to};

    always #5 clk = ~clk;

    run_ctrl_eot dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_wr_en(mem_wr_en), .mem_wr_dest(mem_wr_dest), .mem_wr_data(mem_wr_data),
        .hold_pc(hold_pc), .hold_instr(hold_instr), .rf_clear(rf_clear),
        .running(running), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    run_ctrl_eot #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(start_to),
        .mem_wr_en(mem_wr_en), .mem_wr_dest(mem_wr_dest), .mem_wr_data(mem_wr_data),
        .hold_pc(hold_pc_to), .hold_instr(hold_instr_to), .rf_clear(rf_clear_to),
        .running(running_to), .done(done_to), .timeout(timeout_to), .cycle_count(cycle_count_to)
    );

    run_ctrl_eot #(.CW(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .start(start_c8),
        .mem_wr_en(mem_wr_en), .mem_wr_dest(mem_wr_dest), .mem_wr_data(mem_wr_data),
        .hold_pc(hold_pc_c8), .hold_instr(hold_instr_c8), .rf_clear(rf_clear_c8),
        .running(running_c8), .done(done_c8), .timeout(timeout_c8), .cycle_count(cycle_count_c8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic en, input logic [15:0] dest, input logic [15:0] data);
        mem_wr_en   = en;
        mem_wr_dest = dest;
        mem_wr_data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (flags !== 6'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: flags=%b count=%0d, expected flags=000000 count=0", flags, cycle_count);
        end
        checks++;
        if (flags_to !== 6'b0 || running_c8 !== 1'b0 || cycle_count_c8 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_other_instances: flags_to=%b count_c8=%0d, expected 0", flags_to, cycle_count_c8);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (flags !== 6'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_release: flags=%b, expected 000000", flags);
        end
    endtask

    task automatic test_hold_sequence();
        logic [5:0] expv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expv = {(i < 9), 1'b1, (i == 9), 3'b000};
            checks++;
            if (flags !== expv) begin
                errors++;
                $display("[TB] FAIL hold_phase%0d: flags=%b, expected %b", i, flags, expv);
            end
            tick();
        end
        checks++;
        if (flags !== 6'b000100 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL run_entry: flags=%b count=%0d, expected 000100 count=0", flags, cycle_count);
        end
    endtask

    // Starts on RUN cycle 1; three near-miss writes must only advance the counter.
    task automatic test_near_miss();
        logic [32:0] vec [3];
        vec[0] = {1'b1, 16'hd075, 16'hd074};
        vec[1] = {1'b1, 16'hd074, 16'h0000};
        vec[2] = {1'b0, 16'hd074, 16'hd074};
        for (int i = 0; i < 3; i++) begin
            drive_mem(vec[i][32], vec[i][31:16], vec[i][15:0]);
            tick();
            checks++;
            if (flags !== 6'b000100 || cycle_count !== 32'(i + 1)) begin
                errors++;
                $display("[TB] FAIL near_miss%0d: flags=%b count=%0d, expected 000100 count=%0d", i, flags, cycle_count, i + 1);
            end
        end
        drive_mem(1'b0, 16'h0, 16'h0);
    endtask

    // Starts on RUN cycle 4; the signature is written on RUN cycle 25.
    task automatic test_eot();
        repeat (21) tick();
        checks++;
        if (cycle_count !== 32'd24 || running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_match_count: count=%0d running=%b, expected 24 and 1", cycle_count, running);
        end
        drive_mem(1'b1, 16'hd074, 16'hd074);
        tick();
        checks++;
        if (flags !== 6'b000100 || cycle_count !== 32'd25) begin
            errors++;
            $display("[TB] FAIL match_count: flags=%b count=%0d, expected 000100 count=25", flags, cycle_count);
        end
        for (int d = 2; d <= 5; d++) begin
            if (d != 2) drive_mem(1'b0, 16'h0, 16'h0);
            tick();
            checks++;
            if (flags !== 6'b000100 || cycle_count !== 32'd25) begin
                errors++;
                $display("[TB] FAIL drain_cycle%0d: flags=%b count=%0d, expected 000100 count=25", d, flags, cycle_count);
            end
        end
        drive_mem(1'b0, 16'h0, 16'h0);
        tick();
        checks++;
        if (flags !== 6'b000010 || cycle_count !== 32'd25) begin
            errors++;
            $display("[TB] FAIL done_state: flags=%b count=%0d, expected 000010 count=25", flags, cycle_count);
        end
        repeat (3) tick();
        checks++;
        if (flags !== 6'b000010 || cycle_count !== 32'd25) begin
            errors++;
            $display("[TB] FAIL done_holds: flags=%b count=%0d, expected 000010 count=25", flags, cycle_count);
        end
    endtask

    // From DONE: a second start inside HOLD must not lengthen or restart the HOLD.
    task automatic test_restart();
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags !== 6'b110000 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL restart_entry: flags=%b count=%0d, expected 110000 count=0", flags, cycle_count);
        end
        n = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) start = 1'b1;
            tick();
            start = 1'b0;
            if (hold_instr) n++;
            else break;
        end
        checks++;
        if (n !== 10 || running !== 1'b1 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL restart_hold_len: hold=%0d running=%b count=%0d, expected 10, 1, 0", n, running, cycle_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        repeat (4) tick();
        drive_mem(1'b1, 16'hd074, 16'hd074);
        tick();
        drive_mem(1'b0, 16'h0, 16'h0);
        tick();
        checks++;
        if (running !== 1'b1 || cycle_count !== 32'd5) begin
            errors++;
            $display("[TB] FAIL drain_before_reset: running=%b count=%0d, expected 1 and 5", running, cycle_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flags !== 6'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: flags=%b count=%0d, expected 000000 count=0", flags, cycle_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (flags !== 6'b110000 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL restart_after_reset: flags=%b count=%0d, expected 110000 count=0", flags, cycle_count);
        end
        repeat (10) tick();
        checks++;
        if (flags !== 6'b000100 || cycle_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL run_after_reset: flags=%b count=%0d, expected 000100 count=0", flags, cycle_count);
        end
    endtask

    task automatic test_timeout();
        start_to = 1'b1;
        tick();
        start_to = 1'b0;
        repeat (10) tick();
        repeat (99) tick();
        checks++;
        if (flags_to !== 6'b000100 || cycle_count_to !== 32'd99) begin
            errors++;
            $display("[TB] FAIL timeout_pre: flags=%b count=%0d, expected 000100 count=99", flags_to, cycle_count_to);
        end
        tick();
        checks++;
        if (flags_to !== 6'b000011 || cycle_count_to !== 32'd100) begin
            errors++;
            $display("[TB] FAIL timeout_done: flags=%b count=%0d, expected 000011 count=100", flags_to, cycle_count_to);
        end
    endtask

    task automatic test_timeout_vs_match();
        start_to = 1'b1;
        tick();
        start_to = 1'b0;
        checks++;
        if (flags_to !== 6'b110000 || cycle_count_to !== 32'd0) begin
            errors++;
            $display("[TB] FAIL to_restart_clear: flags=%b count=%0d, expected 110000 count=0", flags_to, cycle_count_to);
        end
        repeat (10) tick();
        repeat (99) tick();
        drive_mem(1'b1, 16'hd074, 16'hd074);
        tick();
        drive_mem(1'b0, 16'h0, 16'h0);
        checks++;
        if (flags_to !== 6'b000100 || cycle_count_to !== 32'd100) begin
            errors++;
            $display("[TB] FAIL match_beats_timeout: flags=%b count=%0d, expected 000100 count=100", flags_to, cycle_count_to);
        end
        repeat (5) tick();
        checks++;
        if (flags_to !== 6'b000010 || cycle_count_to !== 32'd100) begin
            errors++;
            $display("[TB] FAIL match_done_no_timeout: flags=%b count=%0d, expected 000010 count=100", flags_to, cycle_count_to);
        end
    endtask

    task automatic test_saturation();
        start_c8 = 1'b1;
        tick();
        start_c8 = 1'b0;
        repeat (10) tick();
        repeat (254) tick();
        checks++;
        if (cycle_count_c8 !== 8'd254 || running_c8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_pre: count=%0d running=%b, expected 254 and 1", cycle_count_c8, running_c8);
        end
        repeat (40) tick();
        checks++;
        if (cycle_count_c8 !== 8'd255 || running_c8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_hold: count=%0d running=%b, expected 255 and 1", cycle_count_c8, running_c8);
        end
    endtask

    initial begin
        test_reset();
        test_hold_sequence();
        test_near_miss();
        test_eot();
        test_restart();
        test_reset_mid_drain();
        test_timeout();
        test_timeout_vs_match();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
